// File: rtl/wishbone_arb_pkg.sv
// ----------------------------------------------------------------------------
// wishbone_arb_pkg
//   Shared types and helpers for the Wishbone round-robin arbiter.
//   - arb_state_e : arbiter FSM state (idle / bus granted)
//   - cti_e       : Wishbone cycle-type encodings used on the bus
//   - gnt_idx_w() : width of a binary grant index for n masters
// ----------------------------------------------------------------------------
package wishbone_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_INCR    = 3'b010,
      CTI_EOB     = 3'b111
   } cti_e;

   // A single master still needs a one-bit index so vectors stay legal.
   function automatic int gnt_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wishbone_arbiter_if.sv
// ----------------------------------------------------------------------------
// wishbone_arbiter_if
//   Bundle of every bus signal around the arbiter: NUM_M packed master ports
//   on one side, the single shared slave port on the other, plus the grant.
//
//   Handshake: a master owns a bus tenure while its CYC is high; STB (only
//   meaningful with CYC) marks a valid request, and the transfer completes in
//   the cycle where STB is high together with exactly one of ACK/ERR/RTY.
//   There is no separate ready: the termination is the acceptance.
//
//   Modports:
//     master : the arbiter's view (samples M_*_I and S_*_I, drives the rest)
//     slave  : the environment's view (masters + slave model), the reverse
// ----------------------------------------------------------------------------
interface wishbone_arbiter_if #(
   parameter int NUM_M     = 4,
   parameter int WB_ADDR_W = 32,
   parameter int WB_DATA_W = 32
);
   localparam int SW = WB_DATA_W / 8;

   // master side
   logic [NUM_M-1:0]           M_CYC_I;
   logic [NUM_M-1:0]           M_STB_I;
   logic [NUM_M-1:0]           M_WE_I;
   logic [NUM_M-1:0]           M_LOCK_I;
   logic [NUM_M*WB_ADDR_W-1:0] M_ADR_I;
   logic [NUM_M*WB_DATA_W-1:0] M_DAT_I;
   logic [NUM_M*SW-1:0]        M_SEL_I;
   logic [NUM_M*3-1:0]         M_CTI_I;
   logic [NUM_M*2-1:0]         M_BTE_I;
   logic [WB_DATA_W-1:0]       M_DAT_O;
   logic [NUM_M-1:0]           M_ACK_O;
   logic [NUM_M-1:0]           M_ERR_O;
   logic [NUM_M-1:0]           M_RTY_O;

   // slave side
   logic                       S_CYC_O;
   logic                       S_STB_O;
   logic                       S_WE_O;
   logic                       S_LOCK_O;
   logic [WB_ADDR_W-1:0]       S_ADR_O;
   logic [WB_DATA_W-1:0]       S_DAT_O;
   logic [SW-1:0]              S_SEL_O;
   logic [2:0]                 S_CTI_O;
   logic [1:0]                 S_BTE_O;
   logic [WB_DATA_W-1:0]       S_DAT_I;
   logic                       S_ACK_I;
   logic                       S_ERR_I;
   logic                       S_RTY_I;

   // one-hot current owner
   logic [NUM_M-1:0]           GNT_O;

   modport master (
      input  M_CYC_I, M_STB_I, M_WE_I, M_LOCK_I, M_ADR_I, M_DAT_I, M_SEL_I,
             M_CTI_I, M_BTE_I, S_DAT_I, S_ACK_I, S_ERR_I, S_RTY_I,
      output M_DAT_O, M_ACK_O, M_ERR_O, M_RTY_O, S_CYC_O, S_STB_O, S_WE_O,
             S_LOCK_O, S_ADR_O, S_DAT_O, S_SEL_O, S_CTI_O, S_BTE_O, GNT_O
   );

   modport slave (
      output M_CYC_I, M_STB_I, M_WE_I, M_LOCK_I, M_ADR_I, M_DAT_I, M_SEL_I,
             M_CTI_I, M_BTE_I, S_DAT_I, S_ACK_I, S_ERR_I, S_RTY_I,
      input  M_DAT_O, M_ACK_O, M_ERR_O, M_RTY_O, S_CYC_O, S_STB_O, S_WE_O,
             S_LOCK_O, S_ADR_O, S_DAT_O, S_SEL_O, S_CTI_O, S_BTE_O, GNT_O
   );

endinterface

// File: rtl/wb_rr_picker.sv
// ----------------------------------------------------------------------------
// wb_rr_picker
//   Combinational round-robin selector. Searches i_req starting at i_ptr+1
//   and wrapping, so the last winner (i_ptr) has the lowest priority.
//   Ports:
//     i_req     : request vector, one bit per master
//     i_ptr     : index of the previous winner
//     o_gnt_oh  : one-hot winner (zero when no request)
//     o_gnt_idx : binary winner index (zero when no request)
//     o_vld     : any request present
// ----------------------------------------------------------------------------
module wb_rr_picker
   import wishbone_arb_pkg::*;
#(
   parameter int NUM_M = 4,
   parameter int IW    = gnt_idx_w(NUM_M)
) (
   input  logic [NUM_M-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic [NUM_M-1:0] o_gnt_oh,
   output logic [IW-1:0]    o_gnt_idx,
   output logic             o_vld
);

   int w_j;

   always_comb begin
      o_gnt_oh  = '0;
      o_gnt_idx = '0;
      o_vld     = 1'b0;
      w_j       = 0;
      // i runs 1..NUM_M so the previous winner is examined last.
      for (int i = 1; i <= NUM_M; i++) begin
         w_j = int'(i_ptr) + i;
         if (w_j >= NUM_M) w_j = w_j - NUM_M;
         if (!o_vld && i_req[w_j]) begin
            o_vld         = 1'b1;
            o_gnt_idx     = IW'(w_j);
            o_gnt_oh[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wishbone_arbiter.sv
// ----------------------------------------------------------------------------
// wishbone_arbiter
//   Shares one Wishbone slave between NUM_M masters. Round-robin decision is
//   made once per tenure in IDLE; the grant is then held while the owner keeps
//   CYC high, or keeps LOCK high between cycles. One IDLE cycle separates
//   consecutive tenures.
//   Ports:
//     CLK_I        : clock
//     RST_I        : asynchronous active-low reset
//     bus          : wishbone_arbiter_if.master (masters, slave, GNT_O)
//     o_dbg_state  : current FSM state
//     o_dbg_to_cnt : stall counter (always zero without the timeout feature)
//   Optional: define WB_ARB_TIMEOUT_EN to abort a request that stalls for
//   TIMEOUT_CYC cycles with a one-cycle ERR to the owner.
// ----------------------------------------------------------------------------
module wishbone_arbiter
   import wishbone_arb_pkg::*;
#(
   parameter int NUM_M       = 4,
   parameter int WB_ADDR_W   = 32,
   parameter int WB_DATA_W   = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                           CLK_I,
   input  logic                           RST_I,
   wishbone_arbiter_if.master             bus,
   output arb_state_e                     o_dbg_state,
   output logic [$clog2(TIMEOUT_CYC):0]   o_dbg_to_cnt
);

   localparam int IW   = gnt_idx_w(NUM_M);
   localparam int SW   = WB_DATA_W / 8;
   localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

   arb_state_e       r_state;
   logic [NUM_M-1:0] r_gnt;
   logic [IW-1:0]    r_gnt_idx;
   logic [IW-1:0]    r_ptr;

   logic [NUM_M-1:0] w_pick_oh;
   logic [IW-1:0]    w_pick_idx;
   logic             w_pick_vld;

   logic             w_active;
   logic             w_m_cyc;
   logic             w_m_lock;
   logic             w_s_cyc;
   logic             w_stb_raw;
   logic             w_to_hit;

   wb_rr_picker #(
      .NUM_M (NUM_M),
      .IW    (IW)
   ) u_picker (
      .i_req     (bus.M_CYC_I),
      .i_ptr     (r_ptr),
      .o_gnt_oh  (w_pick_oh),
      .o_gnt_idx (w_pick_idx),
      .o_vld     (w_pick_vld)
   );

   assign w_active  = (r_state == ARB_GRANT);
   assign w_m_cyc   = bus.M_CYC_I[r_gnt_idx];
   assign w_m_lock  = bus.M_LOCK_I[r_gnt_idx];
   assign w_s_cyc   = w_active & w_m_cyc;
   assign w_stb_raw = w_s_cyc & bus.M_STB_I[r_gnt_idx];

   // --------------------------------------------------------------------------
   // Arbitration FSM. The grant is registered; the data path below is a pure
   // mux of the owner's signals, so reset clears the slave strobes at once.
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_state   <= ARB_IDLE;
         r_gnt     <= '0;
         r_gnt_idx <= '0;
         r_ptr     <= IW'(NUM_M - 1);   // master 0 searched first
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_pick_vld) begin
                  r_gnt     <= w_pick_oh;
                  r_gnt_idx <= w_pick_idx;
                  r_ptr     <= w_pick_idx;
                  r_state   <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               // LOCK keeps ownership across a gap in CYC.
               if (!w_m_cyc && !w_m_lock) begin
                  r_gnt   <= '0;
                  r_state <= ARB_IDLE;
               end
            end
            default: begin
               r_gnt   <= '0;
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign bus.GNT_O   = r_gnt;
   assign o_dbg_state = r_state;

   // --------------------------------------------------------------------------
   // Stall timeout
   // --------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
   logic [TO_W-1:0] r_to_cnt;
   logic            w_term;

   assign w_term   = bus.S_ACK_I | bus.S_ERR_I | bus.S_RTY_I;
   assign w_to_hit = w_stb_raw & ~w_term & (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_to_cnt <= '0;
      end else if (!w_stb_raw || w_term || w_to_hit) begin
         // Also covers state changes: STB is never raw-valid outside GRANT.
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   assign o_dbg_to_cnt = r_to_cnt;
`else
   assign w_to_hit     = 1'b0;
   assign o_dbg_to_cnt = '0;
`endif

   // --------------------------------------------------------------------------
   // Bus mux and termination routing
   // --------------------------------------------------------------------------
   always_comb begin
      bus.S_CYC_O  = w_s_cyc;
      bus.S_STB_O  = w_stb_raw & ~w_to_hit;
      bus.S_WE_O   = w_active & bus.M_WE_I[r_gnt_idx];
      bus.S_LOCK_O = w_active & w_m_lock;
      bus.S_ADR_O  = '0;
      bus.S_DAT_O  = '0;
      bus.S_SEL_O  = '0;
      bus.S_CTI_O  = CTI_CLASSIC;
      bus.S_BTE_O  = '0;
      if (w_active) begin
         bus.S_ADR_O = bus.M_ADR_I[r_gnt_idx*WB_ADDR_W +: WB_ADDR_W];
         bus.S_DAT_O = bus.M_DAT_I[r_gnt_idx*WB_DATA_W +: WB_DATA_W];
         bus.S_SEL_O = bus.M_SEL_I[r_gnt_idx*SW +: SW];
         bus.S_CTI_O = bus.M_CTI_I[r_gnt_idx*3 +: 3];
         bus.S_BTE_O = bus.M_BTE_I[r_gnt_idx*2 +: 2];
      end

      bus.M_DAT_O = bus.S_DAT_I;
      bus.M_ACK_O = '0;
      bus.M_ERR_O = '0;
      bus.M_RTY_O = '0;
      // Terminations while the slave sees no cycle are stray and dropped.
      if (w_s_cyc) begin
         bus.M_ACK_O[r_gnt_idx] = bus.S_ACK_I;
         bus.M_ERR_O[r_gnt_idx] = bus.S_ERR_I | w_to_hit;
         bus.M_RTY_O[r_gnt_idx] = bus.S_RTY_I;
      end
   end

endmodule
